// File: rtl/sdpb_arbiter_if.sv
// Requester and RAM-side signal bundle for sdpb_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sdpb_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              req0_valid, req1_valid;
  logic              req0_we,    req1_we;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_gnt,   req1_gnt;
  logic              req0_rvalid, req1_rvalid;
  logic [DATA_W-1:0] req0_rdata, req1_rdata;
  logic              ram_cea;
  logic [ADDR_W-1:0] ram_ada;
  logic [DATA_W-1:0] ram_din;
  logic              ram_ceb;
  logic [ADDR_W-1:0] ram_adb;
  logic              ram_oce;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we,
    input  req0_addr, req1_addr, req0_wdata, req1_wdata,
    output req0_gnt, req1_gnt, req0_rvalid, req1_rvalid,
    output req0_rdata, req1_rdata,
    output ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce,
    input  ram_dout
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we,
    output req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  req0_gnt, req1_gnt, req0_rvalid, req1_rvalid,
    input  req0_rdata, req1_rdata,
    input  ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce,
    output ram_dout
  );
endinterface

// File: rtl/sdpb_arbiter.sv
// Two-requester arbiter for a simple-dual-port RAM; write and read ports arbitrate independently.
// Optional same-cycle write-to-read forwarding is enabled by defining SDPB_ARB_WR_FWD_EN.
module sdpb_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input logic           clk,
  input logic           rst,
  sdpb_arbiter_if.slave bus
);
  // Handshake: a transfer happens on a rising edge with valid=1 and gnt=1; gnt is
  // combinational, never asserts without valid, and an ungranted requester holds its
  // we/addr/wdata stable until granted.
  logic wr_c0, wr_c1, rd_c0, rd_c1;
  logic wr_pick0, rd_pick0;
  logic wr_g0, wr_g1, rd_g0, rd_g1;
  logic wr_last_q, wr_last_d;
  logic rd_last_q, rd_last_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0] rdata_sel;

  always_comb begin
    wr_c0 = !rst & bus.req0_valid &  bus.req0_we;
    wr_c1 = !rst & bus.req1_valid &  bus.req1_we;
    rd_c0 = !rst & bus.req0_valid & !bus.req0_we;
    rd_c1 = !rst & bus.req1_valid & !bus.req1_we;
    // Last winner 1 means req0 takes the next conflict.
    wr_pick0 = (FIXED_PRIO != 0) | wr_last_q;
    rd_pick0 = (FIXED_PRIO != 0) | rd_last_q;
    wr_g0 = wr_c0 & (!wr_c1 |  wr_pick0);
    wr_g1 = wr_c1 & (!wr_c0 | !wr_pick0);
    rd_g0 = rd_c0 & (!rd_c1 |  rd_pick0);
    rd_g1 = rd_c1 & (!rd_c0 | !rd_pick0);
    wr_last_d = (wr_g0 | wr_g1) ? wr_g1 : wr_last_q;
    rd_last_d = (rd_g0 | rd_g1) ? rd_g1 : rd_last_q;
    rd_pend_d = rd_g0 | rd_g1;
    rd_tag_d  = rd_g1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_last_q <= 1'b1;
      rd_last_q <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      wr_last_q <= wr_last_d;
      rd_last_q <= rd_last_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

`ifdef SDPB_ARB_WR_FWD_EN
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  always_comb begin
    fwd_hit_d  = bus.ram_cea & bus.ram_ceb & (bus.ram_ada == bus.ram_adb);
    fwd_data_d = bus.ram_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rdata_sel = fwd_hit_q ? fwd_data_q : bus.ram_dout;
`else
  assign rdata_sel = bus.ram_dout;
`endif

  assign bus.req0_gnt    = wr_g0 | rd_g0;
  assign bus.req1_gnt    = wr_g1 | rd_g1;
  assign bus.req0_rvalid = rd_pend_q & !rd_tag_q;
  assign bus.req1_rvalid = rd_pend_q &  rd_tag_q;
  assign bus.req0_rdata  = rdata_sel;
  assign bus.req1_rdata  = rdata_sel;

  assign bus.ram_cea = wr_g0 | wr_g1;
  assign bus.ram_ada = wr_g0 ? bus.req0_addr  : (wr_g1 ? bus.req1_addr  : '0);
  assign bus.ram_din = wr_g0 ? bus.req0_wdata : (wr_g1 ? bus.req1_wdata : '0);
  assign bus.ram_ceb = rd_g0 | rd_g1;
  assign bus.ram_adb = rd_g0 ? bus.req0_addr  : (rd_g1 ? bus.req1_addr  : '0);
  assign bus.ram_oce = 1'b1;
endmodule

// File: doc/sdpb_arbiter.md
Name: sdpb_arbiter

Overview:
- Shares one 2K x 8 simple-dual-port block RAM (separate write and read ports, 1-cycle read latency, bypass output mode) between two requesters: req0 is the CPU data bus and req1 is the UART program loader.
- The write port and the read port are arbitrated independently. A read from one requester and a write from the other can be granted in the same cycle.
- Sits between the CPU/loader buses and the RAM primitive wrapper in the board top.

Parameters:
- ADDR_W, 11, RAM address width in words.
- DATA_W, 8, RAM data width.
- FIXED_PRIO, 0: 0 = round-robin per port; 1 = req0 always wins on conflict.

Ports:
- clk  in  1  single system clock; RAM clka/clkb tied to it.
- rst  in  1  asynchronous reset, active-high.
- req0_valid, req1_valid  in  1 each  request present.
- req0_we, req1_we  in  1 each  1 = write, 0 = read.
- req0_addr, req1_addr  in  ADDR_W each  word address.
- req0_wdata, req1_wdata  in  DATA_W each  write data.
- req0_gnt, req1_gnt  out  1 each  request accepted this cycle (combinational).
- req0_rvalid, req1_rvalid  out  1 each  read data valid (registered).
- req0_rdata, req1_rdata  out  DATA_W each  read data; qualified by rvalid.
- ram_cea  out  1  write enable/clock enable of the write port.
- ram_ada  out  ADDR_W  write address.
- ram_din  out  DATA_W  write data.
- ram_ceb  out  1  read clock enable.
- ram_adb  out  ADDR_W  read address.
- ram_oce  out  1  output clock enable; constant 1.
- ram_dout  in  DATA_W  RAM read data, valid the cycle after ram_ceb.
- The RAM reseta/resetb inputs are tied low in the top.

Behaviour:
- Handshake and ordering:
  - A transfer occurs on a rising edge where valid=1 and gnt=1.
  - While valid is high and gnt is low, the requester holds we/addr/wdata stable.
  - gnt never asserts without valid.
- Write port:
  - Write candidates are requesters with valid & we.
  - One candidate: grant it.
  - Two candidates: grant per the priority rule.
  - ram_cea = any write grant. ram_ada/ram_din come from the winner; they are 0 when no winner.
- Read port:
  - Same scheme for valid & !we.
  - ram_ceb = any read grant; ram_adb comes from the winner.
- Priority:
  - Round-robin keeps a separate 1-bit last-winner register per port (wr_last, rd_last). Both reset to 1, so req0 wins the first conflict.
  - The register updates only on a granted conflict-free or conflict cycle of that port, to the index of the winner.
  - With FIXED_PRIO=1 these registers are unused.
- Read return:
  - rd_pend (1 bit) and rd_tag (1 bit) are registered on a read grant.
  - The next cycle, reqN_rvalid = rd_pend & (rd_tag==N).
  - Both rdata outputs = ram_dout (or the forwarded value, see Optional Feature).
  - Back-to-back reads every cycle are supported: throughput is 1 read per cycle, latency 1 cycle from grant to rvalid.
- Same requester cannot read and write in one cycle (single we bit).
- Reset values (while rst is high): gnt outputs 0, rvalid outputs 0, ram_cea 0, ram_ceb 0, wr_last/rd_last 1, rd_pend 0, forward regs 0.
- Boundary cases:
  - Address 0 and address 2**ADDR_W-1: no special handling, no wrap logic.
  - Reset asserted in the cycle after a read grant: rvalid is suppressed and the read is lost; the requester reissues.
  - Reset deassertion: the first grant can occur in the first clock after release.
  - Write and read to the same address in the same cycle: the RAM result is read-old/undefined without forwarding.
  - Continuous conflict on a port under round-robin: grants alternate 0,1,0,1. No requester waits more than 1 cycle.

Optional Feature:
- Macro SDPB_ARB_WR_FWD_EN.
- When defined:
  - On a cycle with a write grant and a read grant to the same address, register fwd_hit=1 and fwd_data=written data.
  - The following cycle, rdata = fwd_data instead of ram_dout.
  - Result: read-after-write coherence within the same cycle.
- When undefined:
  - No forward registers exist; rdata = ram_dout always.
  - Same-cycle same-address read data is don't-care.

Test Plan:
- Reset, then req1 writes 0x5A to 0x123, then req0 reads 0x123 -> req1_gnt high in cycle 1, ram_cea=1, ram_ada=0x123; read granted in cycle 2; req0_rvalid=1, req0_rdata=0x5A in cycle 3.
- Both requesters write (req0 0x010<=0x11, req1 0x011<=0x22) for 4 cycles, FIXED_PRIO=0 -> grants 0,1,0,1; final reads return 0x11 and 0x22.
- Same conflict with FIXED_PRIO=1 -> req0_gnt every cycle, req1_gnt never while req0_valid is high.
- req0 reads 0x7FF while req1 writes 0x000 in the same cycle -> both gnts high, ram_cea=ram_ceb=1; req0_rvalid next cycle with the prior contents of 0x7FF.
- With SDPB_ARB_WR_FWD_EN: 0x040 holds 0x00; req1 writes 0xC3 to 0x040 and req0 reads 0x040 in the same cycle -> req0_rdata=0xC3 next cycle. Without the macro, the value is not checked.
- Read granted, rst pulsed on the next edge -> req0_rvalid stays 0; after release, gnt outputs, rvalid, ram_cea and ram_ceb are all 0 until new valids arrive.
